// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage feeding the IF/ID pipeline register
//
// Owns the fetch PC and issues one request at a time to a variable-latency
// instruction memory over a req/ack handshake. The fetched instruction sits
// in an output buffer until ID takes it. Stall comes from the hazard unit and
// redirect comes from EX.
//
// Optional feature macro: IF_FETCH_PERF_CNT_EN (adds perf_fetched/perf_stall).
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   stall             ID cannot accept this cycle
//   redirect          taken control transfer from EX, target on redirect_pc
//   imem_req/addr     registered memory request, address held until ack
//   imem_ack/rdata    memory response
//   PC, inst          address and instruction held in the output buffer
//   inst_valid        output buffer holds an instruction
//   IF_ID_Write       IF/ID write enable (inst_valid & ~stall & ~redirect)
//   perf_fetched      instructions handed to ID (feature only)
//   perf_stall        cycles a valid instruction was held by stall (feature only)

module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC,
    output logic [31:0] inst,
    output logic        inst_valid,
`ifdef IF_FETCH_PERF_CNT_EN
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall,
`endif
    output logic        IF_ID_Write
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2,
        FULL = 2'd3
    } state_t;

    state_t      state_q;
    logic [31:0] fetch_pc_q;
    logic [31:0] target_q;
    logic        imem_req_q;
    logic [31:0] imem_addr_q;
    logic [31:0] pc_q;
    logic [31:0] inst_q;
    logic        inst_valid_q;

    // Address the stale request in DROP resolves to: a redirect in the ack
    // cycle itself overrides the saved target.
    logic [31:0] drop_addr_d;
    logic [31:0] redirect_next_d;
    logic [31:0] drop_next_d;
    logic [31:0] addr_next_d;

    assign drop_addr_d     = redirect ? redirect_pc : target_q;
    assign redirect_next_d = redirect_pc + 32'd4;
    assign drop_next_d     = drop_addr_d + 32'd4;
    assign addr_next_d     = imem_addr_q + 32'd4;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            fetch_pc_q   <= RESET_PC;
            target_q     <= 32'd0;
            imem_req_q   <= 1'b0;
            imem_addr_q  <= 32'd0;
            pc_q         <= 32'd0;
            inst_q       <= NOP_INST;
            inst_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    imem_req_q <= 1'b1;
                    state_q    <= REQ;
                    if (redirect) begin
                        imem_addr_q <= redirect_pc;
                        fetch_pc_q  <= redirect_next_d;
                    end else begin
                        imem_addr_q <= fetch_pc_q;
                    end
                end
                REQ: begin
                    if (imem_ack && redirect) begin
                        // Returned instruction is on the wrong path; refetch at the target.
                        imem_addr_q <= redirect_pc;
                        fetch_pc_q  <= redirect_next_d;
                    end else if (imem_ack) begin
                        pc_q         <= imem_addr_q;
                        inst_q       <= imem_rdata;
                        inst_valid_q <= 1'b1;
                        fetch_pc_q   <= addr_next_d;
                        imem_req_q   <= 1'b0;
                        state_q      <= FULL;
                    end else if (redirect) begin
                        // Address must stay stable until ack, so remember the target.
                        target_q <= redirect_pc;
                        state_q  <= DROP;
                    end
                end
                DROP: begin
                    if (imem_ack) begin
                        imem_addr_q <= drop_addr_d;
                        fetch_pc_q  <= drop_next_d;
                        state_q     <= REQ;
                    end else if (redirect) begin
                        target_q <= redirect_pc;
                    end
                end
                FULL: begin
                    if (redirect) begin
                        inst_valid_q <= 1'b0;
                        inst_q       <= NOP_INST;
                        imem_req_q   <= 1'b1;
                        imem_addr_q  <= redirect_pc;
                        fetch_pc_q   <= redirect_next_d;
                        state_q      <= REQ;
                    end else if (!stall) begin
                        // IF/ID captures PC/inst on this same edge.
                        inst_valid_q <= 1'b0;
                        inst_q       <= NOP_INST;
                        imem_req_q   <= 1'b1;
                        imem_addr_q  <= fetch_pc_q;
                        state_q      <= REQ;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = imem_addr_q;
    assign PC          = pc_q;
    assign inst        = inst_q;
    assign inst_valid  = inst_valid_q;
    assign IF_ID_Write = inst_valid_q & ~stall & ~redirect;

`ifdef IF_FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_stall_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetched_q <= 32'd0;
            perf_stall_q   <= 32'd0;
        end else begin
            if (IF_ID_Write) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if (inst_valid_q && stall && !redirect) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - scoreboard bench for if_fetch_unit

module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] PC;
    logic [31:0] inst;
    logic        inst_valid;
    logic        IF_ID_Write;
`ifdef IF_FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    if_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .PC          (PC),
        .inst        (inst),
        .inst_valid  (inst_valid),
`ifdef IF_FETCH_PERF_CNT_EN
        .perf_fetched(perf_fetched),
        .perf_stall  (perf_stall),
`endif
        .IF_ID_Write (IF_ID_Write)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        case (a)
            32'h0000_0000: memf = 32'h0010_0093;
            32'h0000_0008: memf = 32'hDEAD_BEEF;
            default:       memf = a ^ 32'hC0DE_0000;
        endcase
    endfunction

    // Memory model: ack after lat cycles of an outstanding request.
    int   lat = 1;
    int   cnt = 0;
    logic mem_ack = 1'b0;
    logic last_req = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    assign imem_ack   = mem_ack;
    assign imem_rdata = mem_rdata;

    always @(negedge clk) begin
        if (!rst) begin
            mem_ack  <= 1'b0;
            cnt      <= 0;
            last_req <= 1'b0;
        end else begin
            if (imem_req) begin
                cnt       <= ((mem_ack && last_req) ? 0 : cnt) + 1;
                mem_ack   <= ((((mem_ack && last_req) ? 0 : cnt) + 1) >= lat);
                mem_rdata <= memf(imem_addr);
            end else begin
                cnt     <= 0;
                mem_ack <= 1'b0;
            end
            last_req <= imem_req;
        end
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;
    exp_t sb[$];
    logic poison = 1'b0;

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (inst_valid && inst == 32'hDEAD_BEEF) poison = 1'b1;
            if (IF_ID_Write) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_pc", PC, e.pc);
                    chk("sb_inst", inst, e.ins);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a);
        exp_t e;
        e.pc  = a;
        e.ins = memf(a);
        sb.push_back(e);
    endtask

    task automatic wait_full(input string tag);
        int n = 0;
        while (!inst_valid && n < 20) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, inst_valid}, 32'd1);
    endtask

    initial begin
        rst = 1'b0;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'd0;
        tick();
        tick();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_pc", PC, 32'd0);
        chk("rst_inst", inst, NOP);
        chk("rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_wr", {31'd0, IF_ID_Write}, 32'd0);

        // First fetch from RESET_PC, consumed immediately.
        push(32'h0);
        rst = 1'b1;
        tick();
        chk("first_req", {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'd0);
        wait_full("first_full");
        chk("first_wr", {31'd0, IF_ID_Write}, 32'd1);
        tick();
        chk("second_addr", imem_addr, 32'd4);

        // Stall three edges while FULL.
        wait_full("stall_full");
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc", PC, 32'd4);
            chk("stall_inst", inst, memf(32'd4));
            chk("stall_wr", {31'd0, IF_ID_Write}, 32'd0);
            chk("stall_req", {31'd0, imem_req}, 32'd0);
        end
        push(32'd4);
        stall = 1'b0;
        tick();
        chk("post_stall_wr", {31'd0, IF_ID_Write}, 32'd0);
        chk("post_stall_addr", imem_addr, 32'd8);

        // Redirect while REQ: stale data at 8 must be discarded.
        lat = 3;
        redirect = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        for (int i = 0; i < 10 && imem_addr != 32'h100; i++) tick();
        chk("redir_addr", imem_addr, 32'h100);
        chk("redir_valid", {31'd0, inst_valid}, 32'd0);
        lat = 1;
        push(32'h100);
        wait_full("redir_full");
        chk("redir_pc", PC, 32'h100);

        // Two redirects during one DROP: latest wins.
        lat = 4;
        tick();
        chk("drop_addr0", imem_addr, 32'h104);
        redirect = 1'b1;
        redirect_pc = 32'h200;
        tick();
        redirect_pc = 32'h300;
        tick();
        redirect = 1'b0;
        for (int i = 0; i < 10 && imem_addr == 32'h104; i++) tick();
        chk("drop_addr", imem_addr, 32'h300);
        lat = 1;
        push(32'h300);
        wait_full("drop_full");
        tick();
        chk("seq_addr", imem_addr, 32'h304);

        // Redirect coincident with ack in REQ.
        redirect = 1'b1;
        redirect_pc = 32'h40;
        tick();
        redirect = 1'b0;
        chk("ackredir_addr", imem_addr, 32'h40);
        chk("ackredir_valid", {31'd0, inst_valid}, 32'd0);
        wait_full("ackredir_full");
        chk("ackredir_pc", PC, 32'h40);

        // Redirect and stall together in FULL; redirect wins.
        stall = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        #1;
        chk("rs_wr", {31'd0, IF_ID_Write}, 32'd0);
        tick();
        redirect = 1'b0;
        stall = 1'b0;
        chk("rs_valid", {31'd0, inst_valid}, 32'd0);
        chk("rs_inst", inst, NOP);
        chk("rs_addr", imem_addr, 32'hFFFF_FFFC);
        push(32'hFFFF_FFFC);
        wait_full("wrap_full");
        chk("wrap_pc", PC, 32'hFFFF_FFFC);
        tick();
        chk("wrap_addr", imem_addr, 32'd0);
        chk("wrap_req", {31'd0, imem_req}, 32'd1);

`ifdef IF_FETCH_PERF_CNT_EN
        chk("perf_fetched", perf_fetched, 32'd5);
        chk("perf_stall", perf_stall, 32'd3);
`endif

        // Asynchronous reset mid-REQ, away from any edge.
        #2;
        rst = 1'b0;
        #1;
        chk("arst_req", {31'd0, imem_req}, 32'd0);
        chk("arst_valid", {31'd0, inst_valid}, 32'd0);
        chk("arst_inst", inst, NOP);
        chk("arst_addr", imem_addr, 32'd0);
`ifdef IF_FETCH_PERF_CNT_EN
        chk("arst_perf_f", perf_fetched, 32'd0);
        chk("arst_perf_s", perf_stall, 32'd0);
`endif
        tick();
        tick();
        push(32'h0);
        rst = 1'b1;
        tick();
        chk("rerun_addr", imem_addr, 32'd0);
        chk("rerun_req", {31'd0, imem_req}, 32'd1);
        wait_full("rerun_full");
        chk("rerun_pc", PC, 32'd0);
        tick();

        chk("sb_drained", sb.size(), 32'd0);
        chk("no_poison", {31'd0, poison}, 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage that produces the PC/instruction pair consumed by the IF/ID pipeline register, and generates that register's write enable.
- Owns the fetch PC.
- Issues requests to a variable-latency instruction memory using a req/ack handshake.
- Holds each fetched instruction in an output buffer until the ID side accepts it.
- Handles stall from the hazard unit and branch/jump redirect from EX.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset
NOP_INST, 32'h0000_0013, value driven on inst while no valid instruction is held

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
stall  in  1  hazard unit: ID cannot accept this cycle
redirect  in  1  EX: control transfer taken this cycle
redirect_pc  in  32  target address, valid with redirect
imem_req  out  1  memory request, registered
imem_addr  out  32  request address, registered, stable while imem_req=1 until ack
imem_ack  in  1  memory response valid, at least 1 cycle after request start
imem_rdata  in  32  instruction, valid with imem_ack
PC  out  32  address of held instruction
inst  out  32  held instruction
inst_valid  out  1  output buffer holds an instruction
IF_ID_Write  out  1  combinational: inst_valid & ~stall & ~redirect

Behaviour:
- Reset (rst=0, async) sets:
  - state=IDLE, fetch_pc=RESET_PC, imem_req=0, imem_addr=0;
  - PC=0, inst=NOP_INST, inst_valid=0, redirect target reg=0.
- Handshake: a request completes on the edge where imem_req=1 & imem_ack=1.
  - If imem_req stays 1 after that edge, the memory sees a new request at the new imem_addr.
  - imem_ack while imem_req=0 is ignored.
- IDLE: imem_req=0. Next edge: imem_req<=1, imem_addr<=fetch_pc, go REQ.
- REQ (imem_req=1):
  - ack & redirect: discard rdata; imem_addr<=redirect_pc; fetch_pc<=redirect_pc+4; stay REQ.
  - ack & ~redirect: PC<=imem_addr, inst<=imem_rdata, inst_valid<=1; fetch_pc<=imem_addr+4; imem_req<=0; go FULL.
  - ~ack & redirect: target<=redirect_pc; go DROP (addr held).
  - else: hold.
- DROP (imem_req=1, stale request outstanding):
  - redirect updates target (latest wins, including in the ack cycle).
  - On ack: discard rdata; imem_addr<=target (or redirect_pc if redirect that cycle); fetch_pc<=that+4; go REQ.
- FULL (imem_req=0, inst_valid=1):
  - redirect: inst_valid<=0, inst<=NOP_INST; imem_req<=1, imem_addr<=redirect_pc; fetch_pc<=redirect_pc+4; go REQ. IF_ID_Write=0 this cycle (redirect has priority over both stall and drain).
  - ~stall: IF_ID_Write=1, so IF/ID captures PC/inst at this edge; inst_valid<=0, inst<=NOP_INST; imem_req<=1, imem_addr<=fetch_pc; go REQ.
  - stall: hold everything; IF_ID_Write=0.
- Redirect while in IDLE: imem_addr<=redirect_pc, fetch_pc<=redirect_pc+4, go REQ.
- Arithmetic: PC increment is +4 modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0. No alignment checking; redirect_pc is used as given.
- At most one outstanding memory request. inst_valid=1 only in FULL.
- Throughput: one instruction per (memory latency + 1) cycles minimum.

Optional Feature:
IF_FETCH_PERF_CNT_EN
- Defined:
  - adds output perf_fetched[31:0], incremented on each edge with IF_ID_Write=1;
  - adds output perf_stall[31:0], incremented on each edge with inst_valid & stall & ~redirect;
  - both reset to 0 and wrap at 2^32.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release; memory acks 1 cycle after req with 32'h0010_0093 -> imem_addr=0 on first REQ cycle; then PC=0, inst=32'h0010_0093, inst_valid=1, IF_ID_Write=1 with stall=0; next imem_addr=4.
- stall=1 for 3 cycles while FULL -> PC/inst held, IF_ID_Write=0, imem_req=0 for 3 cycles; stall=0 -> one IF_ID_Write pulse, then request to addr+4.
- Redirect to 32'h0000_0100 while REQ, ack 2 cycles later with 32'hDEAD_BEEF -> DEAD_BEEF never appears with inst_valid=1; next imem_addr=32'h100; inst_valid next rises with PC=32'h100.
- Two redirects (0x200 then 0x300) during one DROP -> next request address 0x300.
- Redirect and stall together in FULL with PC=0x40 -> IF_ID_Write=0, inst_valid=0 next cycle, imem_addr=redirect_pc; fetch at 32'hFFFF_FFFC completes -> next imem_addr=0.
- Async reset asserted mid-REQ (no clock edge) -> imem_req=0, inst_valid=0, inst=NOP_INST immediately; after release, fetch restarts at RESET_PC; with IF_FETCH_PERF_CNT_EN, counters read 0.
